// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between the fetch and load/store ports,
// with a memory-mapped IO window decoded on the data port. IDLE -> ACCESS -> RESPOND per transaction.
module mem_bus_arbiter #(
   parameter int MEM_AW = 8,
   parameter int IO_BIT = 22,
   parameter int IO_AW  = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic [31:0]       d_addr,
   input  logic [3:0]        d_wmask,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              io_rd,
   output logic              io_wr,
   output logic [IO_AW-1:0]  io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

   state_t             r_state;
   logic               r_last_d, r_gnt_d, r_is_io, r_wr;
   logic               r_i_ack, r_d_ack;
   logic               r_mem_en, r_io_rd, r_io_wr;
   logic [MEM_AW-1:0]  r_mem_addr;
   logic [3:0]         r_mem_wmask;
   logic [31:0]        r_mem_wdata, r_io_wdata, r_io_hold;
   logic [IO_AW-1:0]   r_io_addr;

   logic               w_gnt, w_gnt_d, w_is_io, w_wr;
   logic [31:0]        w_addr, w_wdata;
   logic [3:0]         w_wmask;
   logic               w_unused;

   // On a tie the port that was not served last wins.
   assign w_gnt   = i_req | d_req;
   assign w_gnt_d = d_req & (~i_req | ~r_last_d);
   assign w_addr  = w_gnt_d ? d_addr  : i_addr;
   assign w_wmask = w_gnt_d ? d_wmask : 4'b0000;
   assign w_wdata = w_gnt_d ? d_wdata : 32'h0;
   assign w_is_io = w_gnt_d & d_addr[IO_BIT];
   assign w_wr    = |w_wmask;
   assign w_unused = ^{i_addr, d_addr};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_last_d    <= 1'b1;
         r_gnt_d     <= 1'b0;
         r_is_io     <= 1'b0;
         r_wr        <= 1'b0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wmask <= 4'b0000;
         r_mem_wdata <= 32'h0;
         r_io_rd     <= 1'b0;
         r_io_wr     <= 1'b0;
         r_io_addr   <= '0;
         r_io_wdata  <= 32'h0;
         r_io_hold   <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt) begin
                  r_state  <= S_ACCESS;
                  r_gnt_d  <= w_gnt_d;
                  r_last_d <= w_gnt_d;
                  r_is_io  <= w_is_io;
                  r_wr     <= w_wr;
                  if (w_is_io) begin
                     r_io_rd    <= ~w_wr;
                     r_io_wr    <= w_wr;
                     r_io_addr  <= w_addr[IO_AW+1:2];
                     r_io_wdata <= w_wdata;
                  end else begin
                     r_mem_en    <= 1'b1;
                     r_mem_addr  <= w_addr[MEM_AW+1:2];
                     r_mem_wmask <= w_wmask;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            S_ACCESS: begin
               // IO read data is only valid while io_rd is up, so hold it for RESPOND.
               if (r_io_rd) r_io_hold <= io_rdata;
               r_mem_en    <= 1'b0;
               r_mem_addr  <= '0;
               r_mem_wmask <= 4'b0000;
               r_mem_wdata <= 32'h0;
               r_io_rd     <= 1'b0;
               r_io_wr     <= 1'b0;
               r_io_addr   <= '0;
               r_io_wdata  <= 32'h0;
               r_i_ack     <= ~r_gnt_d;
               r_d_ack     <= r_gnt_d;
               r_state     <= S_RESPOND;
            end
            S_RESPOND: begin
               r_i_ack <= 1'b0;
               r_d_ack <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign i_ack     = r_i_ack;
   assign d_ack     = r_d_ack;
   assign mem_en    = r_mem_en;
   assign mem_addr  = r_mem_addr;
   assign mem_wmask = r_mem_wmask;
   assign mem_wdata = r_mem_wdata;
   assign io_rd     = r_io_rd;
   assign io_wr     = r_io_wr;
   assign io_addr   = r_io_addr;
   assign io_wdata  = r_io_wdata;

   // RAM data arrives the cycle after mem_en, which is exactly the RESPOND cycle.
   assign i_rdata = r_i_ack ? mem_rdata : 32'h0;
   assign d_rdata = (r_d_ack && !r_wr) ? (r_is_io ? r_io_hold : mem_rdata) : 32'h0;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single-port synchronous program/data RAM between the instruction-fetch port and the load/store port.
- Also decodes a memory-mapped IO window (LEDs, UART) on the data port.
- Sequences each transaction through a 3-state FSM and arbitrates simultaneous requests round-robin.
- Sits between the multi-cycle RV32IM core FSM and the RAM/IO peripherals.

Parameters:
- MEM_AW, 8, RAM word-address width (256 words); byte address bits [MEM_AW+1:2] select the word, higher bits ignored (wrap).
- IO_BIT, 22, data-address bit that selects the IO window instead of RAM.
- IO_AW, 6, IO word-address width; io_addr = d_addr[IO_AW+1:2].

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  32  fetch byte address (word aligned)
- i_rdata  out  32  fetched word, valid when i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request, level, held until d_ack
- d_addr  in  32  data byte address (word aligned)
- d_wmask  in  4  byte write enables; 4'b0000 = read
- d_wdata  in  32  store data
- d_rdata  out  32  load word, valid when d_ack
- d_ack  out  1  one-cycle data completion pulse (reads and writes)
- mem_en  out  1  RAM access strobe
- mem_addr  out  MEM_AW  RAM word address
- mem_wmask  out  4  RAM byte write enables
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, one cycle after mem_en
- io_rd  out  1  IO read strobe
- io_wr  out  1  IO write strobe
- io_addr  out  IO_AW  IO word address
- io_wdata  out  32  IO write data
- io_rdata  in  32  IO read data, combinational while io_rd

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; last_grant=D, so the first tie goes to fetch.
  - All strobes, acks, addresses, masks and wdata = 0.
  - Any pending transaction is abandoned; no ack is issued for it.
- IDLE:
  - Neither req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the port that is not last_grant.
  - On grant: latch addr, wmask, wdata and the is_io flag (d_addr[IO_BIT]; always 0 for fetch), update last_grant, go to ACCESS.
- ACCESS (exactly one cycle):
  - RAM path: registered outputs drive mem_en=1, mem_addr, mem_wmask (fetch: 0), mem_wdata.
  - IO path: io_rd or io_wr=1 for this cycle only; mem_en stays 0.
  - IO read data is captured into a hold register at the end of the cycle.
  - Next state: RESPOND.
- RESPOND (exactly one cycle):
  - Granted port's ack=1.
  - rdata = mem_rdata (RAM) or the IO hold register (IO); writes return 0.
  - Non-granted ack=0 and its rdata=0.
  - Next state: IDLE.
- Latency: request first seen at edge k gives ack high in cycle k+2. Throughput is one transaction per 3 cycles.
- Requester protocol: the requester drops or changes req at the edge that ends its ack cycle. A req still high in IDLE is a new request.
- Inputs changing after grant are ignored; the latched values are used.
- req dropped after grant: the transaction completes, including the write, and ack still pulses.
- Fetch addresses with IO_BIT set go to RAM; there is no IO fetch.
- mem_en, io_rd and io_wr are never asserted together.
- Strobes are never asserted outside ACCESS.

Test Plan:
- Reset: assert resetn=0 mid-run -> all outputs 0 immediately; after release, i_req addr 0x0 gives i_ack exactly 2 cycles after first sampled edge.
- Single fetch: RAM[3]=0x00100093, i_req addr 0x0000000C -> mem_en=1 with mem_addr=3 in ACCESS; i_ack=1 with i_rdata=0x00100093 in RESPOND; d_ack stays 0.
- Tie/round-robin: after reset, i_req and d_req both held continuously -> acks alternate I, D, I, D every 3 cycles; fetch is served first.
- Byte store: RAM[4]=0x11223344, d_req addr 0x10, wmask 4'b0100, wdata 0xAABBCCDD -> mem_wmask=0100 in ACCESS; d_ack; subsequent read of 0x10 returns 0x11BB3344.
- IO: d_req addr 0x00400004, wmask 1111, wdata 0x1F -> io_wr=1 for one cycle, io_addr=1, io_wdata=0x1F, mem_en=0 throughout. An IO read with io_rdata=0x5 -> d_rdata=0x5 on d_ack.
- Reset mid-operation and drop-after-grant:
  - Pulse resetn low in ACCESS -> no ack; next transaction behaves normally.
  - d_req dropped one cycle after grant on a write -> write still performed and d_ack pulses.
